// File: rtl/mem_responder_pkg.sv
// Shared definitions for the memory-side bus responder: region codes, FSM states, defaults.
package mem_responder_pkg;

   localparam int unsigned DefDataW      = 16;
   localparam int unsigned DefAddrW      = 8;
   localparam int unsigned DefRamDepth   = 64;
   localparam int unsigned MaxWaitStates = 15;
   localparam int unsigned WaitCntW      = 4;

   // Address region, taken from the two most significant address bits.
   typedef enum logic [1:0] {
      RegRam = 2'b00,
      RegLed = 2'b01,
      RegSw  = 2'b10,
      RegBad = 2'b11
   } region_e;

   // Access sequencing states.
   typedef enum logic [1:0] {
      StIdle   = 2'b00,
      StWait   = 2'b01,
      StAccess = 2'b10,
      StResp   = 2'b11
   } state_e;

   function automatic region_e region_of(input logic [1:0] sel);
      return region_e'(sel);
   endfunction

endpackage

// File: rtl/mem_responder_ram_sync.sv
// Single-port RAM: synchronous write, registered one-cycle read. Contents are never reset.
module mem_responder_ram_sync #(
   parameter int unsigned DataW = 16,
   parameter int unsigned Depth = 64,
   parameter int unsigned IdxW  = $clog2(Depth)
) (
   input  logic             clk_i,
   input  logic             we_i,
   input  logic             re_i,
   input  logic [IdxW-1:0]  addr_i,
   input  logic [DataW-1:0] wdata_i,
   output logic [DataW-1:0] rdata_o
);

   logic [DataW-1:0] mem_q [Depth];
   logic [DataW-1:0] rdata_q;

   // Write port and registered read port share the same address.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[addr_i] <= wdata_i;
      end
      if (re_i) begin
         rdata_q <= mem_q[addr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: decodes bus accesses into RAM, LED register and synchronised
// switches, with optional wait states and a one-cycle ready handshake.
module mem_responder
   import mem_responder_pkg::*;
#(
   parameter int unsigned DataW      = DefDataW,
   parameter int unsigned AddrW      = DefAddrW,
   parameter int unsigned RamDepth   = DefRamDepth,
   parameter int unsigned WaitStates = 0
) (
   input  logic             clock_i,
   input  logic             reset_i,
   input  logic             req_i,
   input  logic             w_d_i,
   input  logic [AddrW-1:0] addr_i,
   input  logic [DataW-1:0] dout_i,
   input  logic [DataW-1:0] sw_i,
   output logic [DataW-1:0] din_o,
   output logic             ready_o,
   output logic             busy_o,
   output logic [DataW-1:0] ledr_o,
   output logic             bad_addr_o
);

   localparam int unsigned RamIdxW = $clog2(RamDepth);
   localparam logic [WaitCntW-1:0] WaitLast = WaitCntW'(WaitStates - 1);

   state_e                state_q, state_d;
   logic [WaitCntW-1:0]   wait_cnt_q, wait_cnt_d;

   logic                  wr_q;
   logic [AddrW-1:0]      addr_q;
   logic [DataW-1:0]      wdata_q;

   logic [DataW-1:0]      sw_meta_q, sw_sync_q;
   logic [DataW-1:0]      ledr_q;
   logic                  bad_q;
   logic [DataW-1:0]      rsp_q;
   logic [DataW-1:0]      din_q, din_d;

   region_e               region;
   logic                  accept;
   logic                  in_access;
   logic                  ram_we, ram_re;
   logic [DataW-1:0]      ram_rdata;

   assign region = region_of(addr_q[AddrW-1 -: 2]);

   // Next-state logic: accept in idle, count wait states, one access cycle, one response cycle.
   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      accept     = 1'b0;
      in_access  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (req_i) begin
               accept  = 1'b1;
               state_d = (WaitStates > 0) ? StWait : StAccess;
            end
         end
         StWait: begin
            if (wait_cnt_q == WaitLast) begin
               wait_cnt_d = '0;
               state_d    = StAccess;
            end else begin
               wait_cnt_d = wait_cnt_q + 1'b1;
            end
         end
         StAccess: begin
            in_access = 1'b1;
            state_d   = StResp;
         end
         StResp: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State register and wait counter.
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q    <= StIdle;
         wait_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

   // Capture the request; later req pulses are ignored until back in idle.
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         wr_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else if (accept) begin
         wr_q    <= w_d_i;
         addr_q  <= addr_i;
         wdata_q <= dout_i;
      end
   end

   // Two-flop synchroniser for the asynchronous switch inputs.
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         sw_meta_q <= '0;
         sw_sync_q <= '0;
      end else begin
         sw_meta_q <= sw_i;
         sw_sync_q <= sw_meta_q;
      end
   end

   // RAM strobes only in the access cycle; reset in that cycle suppresses the write.
   assign ram_we = in_access & wr_q & (region == RegRam) & ~reset_i;
   assign ram_re = in_access & ~wr_q & (region == RegRam);

   mem_responder_ram_sync #(
      .DataW (DataW),
      .Depth (RamDepth),
      .IdxW  (RamIdxW)
   ) u_ram (
      .clk_i   (clock_i),
      .we_i    (ram_we),
      .re_i    (ram_re),
      .addr_i  (addr_q[RamIdxW-1:0]),
      .wdata_i (wdata_q),
      .rdata_o (ram_rdata)
   );

   // Access-cycle side effects: LED write, sticky bad-address flag, non-RAM read data.
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         ledr_q <= '0;
         bad_q  <= 1'b0;
         rsp_q  <= '0;
      end else if (in_access) begin
         if (wr_q && (region == RegLed)) begin
            ledr_q <= wdata_q;
         end
         if (region == RegBad) begin
            bad_q <= 1'b1;
         end
         unique case (region)
            RegLed:  rsp_q <= ledr_q;
            RegSw:   rsp_q <= sw_sync_q;
            default: rsp_q <= '0;
         endcase
      end
   end

   // Read data appears with ready (RAM data arrives on that same edge) and is then held.
   always_comb begin
      din_d = din_q;
      if ((state_q == StResp) && !wr_q) begin
         din_d = (region == RegRam) ? ram_rdata : rsp_q;
      end
   end

   // Holding register for the last completed read.
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         din_q <= '0;
      end else begin
         din_q <= din_d;
      end
   end

   assign din_o      = din_d;
   assign ready_o    = (state_q == StResp);
   assign busy_o     = (state_q != StIdle);
   assign ledr_o     = ledr_q;
   assign bad_addr_o = bad_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: one instance without wait states, one with three, both checked
// against a region-level model of the memory map.
module tb_mem_responder;

   logic        clk = 1'b0;
   logic        rst   [2];
   logic        req   [2];
   logic        w_d   [2];
   logic [7:0]  addr  [2];
   logic [15:0] dout  [2];
   logic [15:0] sw    [2];
   logic [15:0] din   [2];
   logic        ready [2];
   logic        busy  [2];
   logic [15:0] ledr  [2];
   logic        bad   [2];

   // Model state per instance.
   logic [15:0] ram_m [2][64];
   logic [15:0] led_m [2];
   logic [15:0] din_m [2];
   logic [15:0] sw_v  [2];
   logic        bad_m [2];

   int n_cmp = 0;
   int n_mis = 0;

   always #5 clk = ~clk;

   mem_responder #(
      .DataW(16), .AddrW(8), .RamDepth(64), .WaitStates(0)
   ) u_dut0 (
      .clock_i(clk), .reset_i(rst[0]), .req_i(req[0]), .w_d_i(w_d[0]), .addr_i(addr[0]),
      .dout_i(dout[0]), .sw_i(sw[0]), .din_o(din[0]), .ready_o(ready[0]), .busy_o(busy[0]),
      .ledr_o(ledr[0]), .bad_addr_o(bad[0])
   );

   mem_responder #(
      .DataW(16), .AddrW(8), .RamDepth(64), .WaitStates(3)
   ) u_dut3 (
      .clock_i(clk), .reset_i(rst[1]), .req_i(req[1]), .w_d_i(w_d[1]), .addr_i(addr[1]),
      .dout_i(dout[1]), .sw_i(sw[1]), .din_o(din[1]), .ready_o(ready[1]), .busy_o(busy[1]),
      .ledr_o(ledr[1]), .bad_addr_o(bad[1])
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Model update from the memory-map rules.
   task automatic model_access(input int d, input logic wr, input logic [7:0] a,
                               input logic [15:0] wd);
      case (a[7:6])
         2'b00: if (wr) ram_m[d][a[5:0]] = wd; else din_m[d] = ram_m[d][a[5:0]];
         2'b01: if (wr) led_m[d] = wd; else din_m[d] = led_m[d];
         2'b10: if (!wr) din_m[d] = sw_v[d];
         default: begin
            bad_m[d] = 1'b1;
            if (!wr) din_m[d] = 16'h0000;
         end
      endcase
   endtask

   task automatic access(input int d, input logic wr, input logic [7:0] a, input logic [15:0] wd);
      int ws;
      int lat;
      ws = (d == 0) ? 0 : 3;
      model_access(d, wr, a, wd);
      @(negedge clk);
      req[d] = 1'b1; w_d[d] = wr; addr[d] = a; dout[d] = wd;
      @(negedge clk);
      req[d] = 1'b0; w_d[d] = 1'($urandom); addr[d] = 8'($urandom); dout[d] = 16'($urandom);
      lat = 1;
      while (ready[d] !== 1'b1 && lat <= 20) begin
         check("busy_before_ready", 32'(busy[d]), 32'd1);
         @(negedge clk);
         lat++;
      end
      check("latency", 32'(lat), 32'(2 + ws));
      if (ready[d] === 1'b1) begin
         check("busy_at_ready", 32'(busy[d]), 32'd1);
         check("din", 32'(din[d]), 32'(din_m[d]));
         check("ledr", 32'(ledr[d]), 32'(led_m[d]));
         check("bad_addr", 32'(bad[d]), 32'(bad_m[d]));
      end
      @(negedge clk);
      check("ready_one_cycle", 32'(ready[d]), 32'd0);
      check("busy_after", 32'(busy[d]), 32'd0);
      check("din_held", 32'(din[d]), 32'(din_m[d]));
   endtask

   task automatic model_reset(input int d);
      led_m[d] = '0; din_m[d] = '0; bad_m[d] = 1'b0; sw_v[d] = sw[d];
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int pulses;
      for (int d = 0; d < 2; d++) begin
         rst[d] = 1'b1; req[d] = 1'b0; w_d[d] = 1'b0; addr[d] = '0; dout[d] = '0; sw[d] = '0;
         model_reset(d);
      end
      repeat (3) @(negedge clk);
      rst[0] = 1'b0; rst[1] = 1'b0;

      // Reset state.
      for (int d = 0; d < 2; d++) begin
         check("rst_din", 32'(din[d]), 32'd0);
         check("rst_ready", 32'(ready[d]), 32'd0);
         check("rst_busy", 32'(busy[d]), 32'd0);
         check("rst_ledr", 32'(ledr[d]), 32'd0);
         check("rst_bad", 32'(bad[d]), 32'd0);
      end

      // RAM write then read, zero and three wait states.
      access(0, 1'b1, 8'h05, 16'h1234);
      access(0, 1'b0, 8'h05, 16'h0000);
      access(1, 1'b1, 8'h05, 16'hCAFE);
      access(1, 1'b0, 8'h05, 16'h0000);

      // Fill both RAMs so every later read has a known expectation.
      for (int d = 0; d < 2; d++)
         for (int k = 0; k < 64; k++)
            access(d, 1'b1, 8'(k), 16'($urandom));

      // LED write leaves DIN alone; readback.
      access(0, 1'b1, 8'h40, 16'h00A5);
      access(0, 1'b0, 8'h40, 16'h0000);

      // Switch read after synchroniser settles; write to switch region is dropped.
      sw[0] = 16'h0F0F; sw_v[0] = 16'h0F0F;
      repeat (3) @(negedge clk);
      access(0, 1'b0, 8'h80, 16'h0000);
      access(0, 1'b1, 8'h80, 16'h7777);

      // Unmapped read; a second req while busy must be ignored.
      model_access(0, 1'b0, 8'hC0, 16'h0000);
      @(negedge clk);
      req[0] = 1'b1; w_d[0] = 1'b0; addr[0] = 8'hC0;
      @(negedge clk);
      w_d[0] = 1'b1; addr[0] = 8'h40; dout[0] = 16'hFFFF;
      pulses = (ready[0] === 1'b1) ? 1 : 0;
      @(negedge clk);
      req[0] = 1'b0;
      check("bad_rd_ready", 32'(ready[0]), 32'd1);
      check("bad_rd_din", 32'(din[0]), 32'd0);
      for (int c = 0; c < 6; c++) begin
         if (ready[0] === 1'b1) pulses++;
         @(negedge clk);
      end
      check("bad_rd_pulses", 32'(pulses), 32'd1);
      check("ignored_req_ledr", 32'(ledr[0]), 32'(led_m[0]));
      check("bad_sticky", 32'(bad[0]), 32'd1);

      // Randomised accesses across all regions.
      for (int i = 0; i < 40; i++) begin
         for (int d = 0; d < 2; d++) begin
            if ($urandom_range(3) == 0) begin
               sw[d] = 16'($urandom); sw_v[d] = sw[d];
               repeat (3) @(negedge clk);
            end
            access(d, 1'($urandom_range(1)), 8'($urandom), 16'($urandom));
         end
      end

      // Reset during the wait phase of an LED write.
      access(1, 1'b1, 8'h40, 16'h5A5A);
      access(1, 1'b0, 8'hC3, 16'h0000);
      @(negedge clk);
      req[1] = 1'b1; w_d[1] = 1'b1; addr[1] = 8'h41; dout[1] = 16'hBEEF;
      @(negedge clk);
      req[1] = 1'b0;
      pulses = 0;
      @(negedge clk);
      rst[1] = 1'b1;
      @(negedge clk);
      rst[1] = 1'b0;
      model_reset(1);
      for (int c = 0; c < 8; c++) begin
         if (ready[1] === 1'b1) pulses++;
         @(negedge clk);
      end
      check("rst_mid_no_ready", 32'(pulses), 32'd0);
      check("rst_mid_ledr", 32'(ledr[1]), 32'd0);
      check("rst_mid_bad", 32'(bad[1]), 32'd0);
      check("rst_mid_din", 32'(din[1]), 32'd0);
      access(1, 1'b0, 8'h41, 16'h0000);
      access(1, 1'b0, 8'h05, 16'h0000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
